// File: rtl/state_loader_pkg.sv
// Shared definitions for the state loader: FSM encoding, default sizes and
// address widths, plus the counter width helper.
package state_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_REGS = 3'd1,
    S_LOAD_MEM  = 3'd2,
    S_DRAIN     = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  localparam int DATA_W_DEF   = 64;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_MEM_DEF  = 64;
  localparam int REG_AW       = 5;
  localparam int MEM_AW       = 6;

  // Bits needed to index 0 .. max(a,b)-1, never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/state_loader_load.sv
// Beat index counter: synchronous clear, increment on accepted beat, and a
// terminal-count flag against a phase-dependent last index. Incrementing at
// terminal count wraps back to zero.
module load_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == last_i);
  assign cnt_o = cnt_q;

  // Next count: clear wins, otherwise advance or wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/state_loader.sv
// Preloads the register file and data memory from a valid/ready word stream,
// then releases the core. Start in RUN reloads from register 0.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for start after reset
// S_LOAD_REGS | accepting register beats 0..NUM_REGS-1 (x0 write masked)
// S_LOAD_MEM  | accepting memory beats 0..NUM_MEM-1
// S_DRAIN     | one cycle while the last memory write completes
// S_RUN       | core released; start triggers a reload
module state_loader
  import state_loader_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_MEM  = NUM_MEM_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_width(NUM_REGS, NUM_MEM);
  localparam logic [CNT_W-1:0] REG_LAST = CNT_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(NUM_MEM - 1);

  state_e             state_q, state_d;
  logic               cnt_clr;
  logic               accept;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_last;
  logic               cnt_tc;

  logic               reg_we_q, mem_we_q, done_q;
  logic [REG_AW-1:0]  reg_addr_q;
  logic [MEM_AW-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  reg_wdata_q, mem_wdata_q;

  assign in_ready = (state_q == S_LOAD_REGS) || (state_q == S_LOAD_MEM);
  assign accept   = in_valid && in_ready;
  assign cnt_last = (state_q == S_LOAD_REGS) ? REG_LAST : MEM_LAST;
  assign busy     = in_ready || (state_q == S_DRAIN);
  assign core_run = (state_q == S_RUN);

  load_counter #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .inc_i  (accept),
    .last_i (cnt_last),
    .cnt_o  (cnt),
    .tc_o   (cnt_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE and RUN.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_REGS;
          cnt_clr = 1'b1;
        end
      end
      S_LOAD_REGS: if (accept && cnt_tc) state_d = S_LOAD_MEM;
      S_LOAD_MEM:  if (accept && cnt_tc) state_d = S_DRAIN;
      S_DRAIN:     state_d = S_RUN;
      S_RUN: begin
        if (start) begin
          state_d = S_LOAD_REGS;
          cnt_clr = 1'b1;
        end
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Write ports: one registered strobe per accepted beat; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= (state_q == S_DRAIN);
      if (accept && (state_q == S_LOAD_REGS)) begin
        reg_we_q    <= (cnt != '0);
        reg_addr_q  <= REG_AW'(cnt);
        reg_wdata_q <= in_data;
      end
      if (accept && (state_q == S_LOAD_MEM)) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= MEM_AW'(cnt);
        mem_wdata_q <= in_data;
      end
    end
  end

  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;

endmodule

// File: tb/tb_state_loader.sv
// Bench for state_loader: beat-count reference model, cycle-by-cycle output
// comparison, directed load scenarios and randomized loads.
module tb_state_loader;
  import state_loader_pkg::*;

  localparam int NR = NUM_REGS_DEF;
  localparam int NM = NUM_MEM_DEF;
  localparam int NB = NR + NM;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready, reg_we, mem_we, core_run, busy, done;
  logic [4:0]  reg_addr;
  logic [5:0]  mem_addr;
  logic [63:0] reg_wdata, mem_wdata;

  state_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_run(core_run),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: where the loader is, measured in accepted beats.
  bit          m_load, m_drain, m_run, m_done;
  int          m_n;
  logic        m_reg_we, m_mem_we;
  logic [4:0]  m_reg_addr;
  logic [5:0]  m_mem_addr;
  logic [63:0] m_reg_wdata, m_mem_wdata;

  logic [63:0] words [NB];
  logic [63:0] got_reg [NR];
  logic [63:0] got_mem [NM];
  int          reg_strobes, mem_strobes;
  int          cyc, done_cyc, last_acc_cyc;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_drain = 0; m_run = 0; m_done = 0; m_n = 0;
    m_reg_we = 0; m_reg_addr = '0; m_reg_wdata = '0;
    m_mem_we = 0; m_mem_addr = '0; m_mem_wdata = '0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_ctl"}, {76'd0, in_ready, busy, core_run, done},
        {76'd0, m_load, m_load | m_drain, m_run, m_done});
    chk({tag, "_reg"}, {10'd0, reg_we, reg_addr, reg_wdata},
        {10'd0, m_reg_we, m_reg_addr, m_reg_wdata});
    chk({tag, "_mem"}, {9'd0, mem_we, mem_addr, mem_wdata},
        {9'd0, m_mem_we, m_mem_addr, m_mem_wdata});
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic st, input logic v);
    bit acc;
    start    = st;
    in_valid = v;
    in_data  = (v && m_load) ? words[m_n] : {$urandom, $urandom};
    acc = m_load && v;
    if (acc && m_n == 0) cyc = 0;
    cyc++;
    m_reg_we = 0; m_mem_we = 0; m_done = 0;
    if (m_load) begin
      if (acc) begin
        if (m_n < NR) begin
          m_reg_we    = (m_n != 0);
          m_reg_addr  = 5'(m_n);
          m_reg_wdata = in_data;
        end else begin
          m_mem_we    = 1;
          m_mem_addr  = 6'(m_n - NR);
          m_mem_wdata = in_data;
        end
        if (m_n == NB - 1) last_acc_cyc = cyc;
        m_n++;
        if (m_n == NB) begin
          m_load  = 0;
          m_drain = 1;
        end
      end
    end else if (m_drain) begin
      m_drain = 0; m_run = 1; m_done = 1;
    end else if (st) begin
      m_load = 1; m_n = 0; m_run = 0;
    end
    @(posedge clk); #1;
    compare_all("cyc");
    if (reg_we) begin reg_strobes++; got_reg[reg_addr] = reg_wdata; end
    if (mem_we) begin mem_strobes++; got_mem[mem_addr] = mem_wdata; end
    if (done) done_cyc = cyc + 1;
  endtask

  task automatic fill_words(input bit rnd);
    for (int i = 0; i < NB; i++)
      words[i] = rnd ? {$urandom, $urandom} : 64'h100 + 64'(i);
  endtask

  task automatic begin_load();
    reg_strobes = 0; mem_strobes = 0;
    done_cyc = -1; last_acc_cyc = -1; cyc = 0;
    for (int i = 0; i < NR; i++) got_reg[i] = 64'hdead;
    for (int i = 0; i < NM; i++) got_mem[i] = 64'hdead;
    step(1'b1, 1'b0);
  endtask

  // vmode 0: continuous, 1: every other cycle, 2: random. start_at pulses
  // start when the model reaches that beat (ignored by the loader).
  task automatic run_load(input int vmode, input int start_at);
    bit tog = 1;
    int k = 0;
    while ((m_load || m_drain) && k < 2000) begin
      logic v, st;
      case (vmode)
        0:       v = 1;
        1:       v = tog;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      tog = ~tog;
      st = (m_load && m_n == start_at) ||
           (vmode == 2 && $urandom_range(0, 7) == 0);
      step(st, v);
      k++;
    end
    chk("finish_core_run", {79'd0, core_run}, 80'd1);
  endtask

  task automatic check_contents(input string tag);
    int errs = 0;
    if (got_reg[0] !== 64'hdead) errs++;
    for (int i = 1; i < NR; i++) if (got_reg[i] !== words[i]) errs++;
    for (int j = 0; j < NM; j++) if (got_mem[j] !== words[NR + j]) errs++;
    chk({tag, "_contents"}, 80'(errs), 80'd0);
    chk({tag, "_reg_strobes"}, 80'(reg_strobes), 80'(NR - 1));
    chk({tag, "_mem_strobes"}, 80'(mem_strobes), 80'(NM));
  endtask

  initial begin
    model_reset();
    #1 compare_all("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 1'b1);            // release cycle: nothing happens
    step(1'b0, 1'b0);

    // Continuous stream of 0x100+i.
    fill_words(0);
    begin_load();
    run_load(0, -1);
    check_contents("cont");
    chk("cont_done_cycle", 80'(done_cyc), 80'd98);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

    // Reload from RUN with in_valid toggling every other cycle.
    begin_load();
    run_load(1, -1);
    check_contents("toggle");
    chk("toggle_last_accept", 80'(last_acc_cyc), 80'd191);
    chk("toggle_done_cycle", 80'(done_cyc), 80'd193);

    // Start pulsed at beat 40 (inside the memory phase) is ignored.
    fill_words(1);
    begin_load();
    run_load(0, 40);
    check_contents("midstart");
    chk("midstart_done_cycle", 80'(done_cyc), 80'd98);

    // Asynchronous reset at register beat 17, then restart from register 0.
    begin_load();
    while (m_n < 17) step(1'b0, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all("midreset");
    rst_n = 1'b1;
    step(1'b0, 1'b1);
    fill_words(1);
    begin_load();
    run_load(0, -1);
    check_contents("restart");

    // Randomized loads with random stalls and spurious start pulses.
    for (int r = 0; r < 4; r++) begin
      fill_words(1);
      repeat ($urandom_range(0, 4)) step(1'b0, 1'($urandom_range(0, 1)));
      begin_load();
      run_load(2, -1);
      check_contents("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/state_loader.md
STATE_LOADER -- requirements
Module: state_loader

Interface
REQ-001 Parameter DATA_W, default 64, width of one architectural word.
REQ-002 Parameter NUM_REGS, default 32, register-file entries to preload.
REQ-003 Parameter NUM_MEM, default 64, data-memory words to preload.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  pulse; begins a load sequence.
REQ-007 in_valid  input  1  load-stream word present.
REQ-008 in_data  input  DATA_W  load-stream word.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 reg_we  output  1  register-file write strobe.
REQ-011 reg_addr  output  5  register index.
REQ-012 reg_wdata  output  DATA_W  register write data.
REQ-013 mem_we  output  1  data-memory write strobe.
REQ-014 mem_addr  output  6  data-memory word index.
REQ-015 mem_wdata  output  DATA_W  memory write data.
REQ-016 core_run  output  1  Tomasulo core permitted to fetch and execute.
REQ-017 busy  output  1  load sequence in progress.
REQ-018 done  output  1  one-cycle pulse when the core is released.

Function
REQ-019 States: IDLE, LOAD_REGS, LOAD_MEM, DRAIN, RUN.
REQ-020 IDLE: start -> LOAD_REGS, index counter cleared to 0; start ignored in LOAD_REGS, LOAD_MEM, DRAIN.
REQ-021 in_ready SHALL be 1 exactly in LOAD_REGS and LOAD_MEM; a beat is accepted when in_valid && in_ready.
REQ-022 Word order: beats 0..NUM_REGS-1 go to registers 0..NUM_REGS-1, next NUM_MEM beats to memory words 0..NUM_MEM-1, ascending, no gaps.
REQ-023 Write latency: beat accepted at edge k -> matching we/addr/wdata registered and high for exactly the cycle after edge k; we low in every cycle with no accepted beat.
REQ-024 Register 0 beat is consumed but reg_we SHALL stay 0 for it (x0 hardwired zero); reg_addr/reg_wdata still update.
REQ-025 Accepting beat NUM_REGS-1 -> LOAD_MEM, counter wraps to 0; accepting memory beat NUM_MEM-1 -> DRAIN.
REQ-026 in_valid low: state and counter hold; no bubble penalty beyond the stall.
REQ-027 DRAIN lasts exactly one cycle (last mem_we completes) -> RUN.
REQ-028 Entering RUN: core_run=1 and done=1 for that first RUN cycle only; core_run held while in RUN.
REQ-029 start in RUN: core_run drops at the same edge, state -> LOAD_REGS, counter 0 (reload).
REQ-030 busy = 1 in LOAD_REGS, LOAD_MEM, DRAIN; 0 otherwise.
REQ-031 Counter width SHALL cover max(NUM_REGS,NUM_MEM)-1; no other wrap than REQ-025.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, counter 0, and in_ready, reg_we, mem_we, core_run, busy, done to 0, addr/wdata outputs to 0.
REQ-033 Reset mid-load SHALL abandon the sequence; already-written targets keep their values; the next start restarts at register 0.
REQ-034 Release of rst_n SHALL take effect on the next rising clk; no writes issued in the release cycle.

Structure
REQ-035 Shared package holds state encoding, DATA_W, NUM_REGS, NUM_MEM defaults and address widths, reused by the core and testbench.
REQ-036 One sub-module, load_counter (clear, increment-on-accept, terminal-count flag), is natural; the FSM and output registers stay in state_loader.

Verification
REQ-037 Reset, start, stream words 0x100+i continuously for 96 beats -> reg_we for regs 1..31 (none for 0), mem_we for mem 0..63 with data 0x120+j, core_run and done in cycle 98 after first accept.
REQ-038 in_valid toggled every other cycle -> identical write contents/order, completion after 191 cycles, no duplicate or missing strobes.
REQ-039 start pulsed during LOAD_MEM at beat 40 -> ignored, sequence completes normally.
REQ-040 rst_n asserted at register beat 17 -> all outputs 0 same cycle; restart loads register 0 first.
REQ-041 start in RUN -> core_run 0 next cycle, in_ready 1, reload writes reg 1 with new beat 1.
REQ-042 Full load then tomasulo execution -> dumped regs_result.dat/mem_result.dat match golden model for the loaded program data.
